mmio_io_controller: RTL

Memory-mapped I/O responder for the 3-stage RISC-V core. Services core loads and stores whose address has bit 31 set: UART receive buffering, UART transmit holding, status, and the cycle/instruction performance counters. Load data is registered so it arrives in the writeback stage one cycle after the execute-stage request. Sits between the core's execute/writeback datapath and the UART byte transmitter and receiver.

---
 rtl/mmio_io_controller_if.sv | 41 ++++
 rtl/mmio_io_controller.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mmio_io_controller_if.sv
// mmio_io_controller_if
//   Groups the core-side load/store bus, the performance-counter enables and
//   the UART byte handshakes that connect to mmio_io_controller.
//
//   Core side : cpu_addr, cpu_wdata, cpu_wr, cpu_rd  -> controller
//               cpu_rdata                            <- controller (registered)
//   Counters  : counter_cycle_valid, counter_inst_valid -> controller
//   UART RX   : rx_data, rx_valid -> controller, rx_ready <- controller
//   UART TX   : tx_data, tx_valid <- controller, tx_ready -> controller
//
//   master : the core/UART side that drives requests and handshakes.
//   slave  : the controller itself.
interface mmio_io_controller_if;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_wr;
  logic        cpu_rd;
  logic [31:0] cpu_rdata;
  logic        counter_cycle_valid;
  logic        counter_inst_valid;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output cpu_addr, cpu_wdata, cpu_wr, cpu_rd,
    output counter_cycle_valid, counter_inst_valid,
    output rx_data, rx_valid, tx_ready,
    input  cpu_rdata, rx_ready, tx_data, tx_valid
  );

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_wr, cpu_rd,
    input  counter_cycle_valid, counter_inst_valid,
    input  rx_data, rx_valid, tx_ready,
    output cpu_rdata, rx_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/mmio_io_controller.sv
// mmio_io_controller
//   Memory-mapped I/O responder for the 3-stage RISC-V core. Responds to
//   loads/stores with cpu_addr[31] set, decoding only cpu_addr[7:0]:
//     0x00 status (bit0 TX free, bit1 RX non-empty)   0x04 RX data (pop)
//     0x08 TX data (write)    0x10 cycle counter      0x14 instruction counter
//     0x18 counter reset (write clears both counters)
//   Load data is registered and appears one cycle after the request.
//
//   Ports:
//     clk  - system clock, rising edge
//     rst  - synchronous active-high reset
//     bus  - mmio_io_controller_if.slave (core bus, counter enables, UART RX/TX)
//   Parameter:
//     RX_DEPTH - receive FIFO depth in bytes (power of two, >= 2)
module mmio_io_controller #(
  parameter int RX_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  mmio_io_controller_if.slave   bus
);

  localparam int AW = $clog2(RX_DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(RX_DEPTH);

  localparam logic [7:0] OFF_STATUS = 8'h00;
  localparam logic [7:0] OFF_RXDATA = 8'h04;
  localparam logic [7:0] OFF_TXDATA = 8'h08;
  localparam logic [7:0] OFF_CYCLE  = 8'h10;
  localparam logic [7:0] OFF_INST   = 8'h14;
  localparam logic [7:0] OFF_CTRCLR = 8'h18;

  logic [7:0]  r_mem [RX_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0] r_count;
  logic [7:0]  r_txData;
  logic        r_txValid;
  logic [31:0] r_cycleCount;
  logic [31:0] r_instCount;
  logic [31:0] r_rdata;

  logic        w_sel;
  logic [7:0]  w_off;
  logic        w_rd;
  logic        w_wr;
  logic        w_empty;
  logic        w_full;
  logic        w_push;
  logic        w_pop;
  logic        w_txDone;
  logic        w_txLoad;
  logic        w_ctrClr;
  logic [31:0] w_rdMux;
  logic        w_unused;

  assign w_sel    = bus.cpu_addr[31];
  assign w_off    = bus.cpu_addr[7:0];
  assign w_rd     = w_sel & bus.cpu_rd;
  assign w_wr     = w_sel & bus.cpu_wr;
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CNT_FULL);
  assign w_push   = bus.rx_valid & ~w_full;
  // Popping an empty FIFO is suppressed; the read then returns 0.
  assign w_pop    = w_rd & (w_off == OFF_RXDATA) & ~w_empty;
  assign w_txDone = r_txValid & bus.tx_ready;
  // A write is only taken when the holding register is already free before
  // this edge, so a write in the handshake-completion cycle is dropped.
  assign w_txLoad = w_wr & (w_off == OFF_TXDATA) & ~r_txValid;
  assign w_ctrClr = w_wr & (w_off == OFF_CTRCLR);
  assign w_unused = ^{bus.cpu_addr[30:8], bus.cpu_wdata[31:8]};

  assign bus.rx_ready  = ~w_full;
  assign bus.tx_data   = r_txData;
  assign bus.tx_valid  = r_txValid;
  assign bus.cpu_rdata = r_rdata;

  // Read multiplexer: everything here is pre-edge state, so a read sees the
  // FIFO, status and counters as they were before this cycle's updates.
  always_comb begin
    w_rdMux = '0;
    case (w_off)
      OFF_STATUS: w_rdMux = {30'b0, ~w_empty, ~r_txValid};
      OFF_RXDATA: w_rdMux = w_empty ? 32'h0 : {24'b0, r_mem[r_rptr]};
      OFF_CYCLE:  w_rdMux = r_cycleCount;
      OFF_INST:   w_rdMux = r_instCount;
      default:    w_rdMux = '0;
    endcase
  end

  // Load data register: only selected reads update it, otherwise it holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (w_rd) begin
      r_rdata <= w_rdMux;
    end
  end

  // RX FIFO storage and pointers. Push and pop are independent, so a
  // simultaneous push/pop advances both pointers and leaves the count alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= bus.rx_data;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // TX holding register. The byte is kept after the handshake so tx_data
  // never changes while tx_valid is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_txData  <= '0;
      r_txValid <= 1'b0;
    end else if (w_txLoad) begin
      r_txData  <= bus.cpu_wdata[7:0];
      r_txValid <= 1'b1;
    end else if (w_txDone) begin
      r_txValid <= 1'b0;
    end
  end

  // Performance counters: a clear write wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || w_ctrClr) begin
      r_cycleCount <= '0;
      r_instCount  <= '0;
    end else begin
      if (bus.counter_cycle_valid) begin
        r_cycleCount <= r_cycleCount + 32'd1;
      end
      if (bus.counter_inst_valid) begin
        r_instCount <= r_instCount + 32'd1;
      end
    end
  end

endmodule
